uart_rx_os: RTL

- Oversampling UART receiver: the consumer end of the baud tick generator.
- Runs on the system clock and advances only on the generator's oversample tick (DIVPULSE, OVERSAMPLING_RATE ticks per bit).
- Synchronises the asynchronous RXD line, qualifies the start bit, majority-votes three mid-bit samples per bit, and emits one byte per frame with error flags.
- Sits between the pin and the RX FIFO / bus interface.

---
 rtl/uart_rx_os_if.sv | 33 +++
 rtl/uart_rx_os.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_os_if.sv
// Pin-side and consumer-side signals of the oversampling UART receiver.
// The receiver is the master: it consumes the tick and line and drives the result.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 DIVPULSE;
    logic                 RXD;
    logic [DATA_BITS-1:0] DATA;
    logic                 DVALID;
    logic                 PERR;
    logic                 FERR;
    logic                 BUSY;

    modport master (
        input  DIVPULSE,
        input  RXD,
        output DATA,
        output DVALID,
        output PERR,
        output FERR,
        output BUSY
    );

    modport slave (
        output DIVPULSE,
        output RXD,
        input  DATA,
        input  DVALID,
        input  PERR,
        input  FERR,
        input  BUSY
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, start qualification,
// 3-sample majority per bit, optional parity, early stop decision and break hold.
module uart_rx_os #(
    parameter int OVERSAMPLING_RATE = 8,
    parameter int DATA_BITS         = 8,
    parameter int PARITY            = 0
) (
    input logic          CLK,
    input logic          NRST,
    uart_rx_os_if.master rx
);
    localparam int TW  = $clog2(OVERSAMPLING_RATE);
    localparam int MID = OVERSAMPLING_RATE / 32'sd2;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING_RATE - 32'sd1);
    localparam logic [TW-1:0] TICK_S0   = TW'(MID - 32'sd1);
    localparam logic [TW-1:0] TICK_S1   = TW'(MID);
    localparam logic [TW-1:0] TICK_S2   = TW'(MID + 32'sd1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 32'sd1);
    localparam logic          PAR_EN    = (PARITY != 32'sd0);
    localparam logic          PAR_ODD   = (PARITY == 32'sd2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Even parity expects XOR(data, parity) = 0, odd expects 1.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return PAR_EN & ((^{d, p}) ^ PAR_ODD);
    endfunction

    state_t                 state_r;
    logic                   rx_meta_r;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic [2:0]             samp_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_r;
    logic [DATA_BITS-1:0]   data_r;
    logic                   dvalid_r;
    logic                   perr_r;
    logic                   ferr_r;
    logic                   busy_r;

    logic                   in_frame_s;
    logic                   bit_end_s;
    logic                   bit_maj_s;
    logic                   stop_maj_s;

    assign in_frame_s = (state_r == ST_START) || (state_r == ST_DATA) ||
                        (state_r == ST_PAR)   || (state_r == ST_STOP);
    assign bit_end_s  = (tick_cnt_r == TICK_LAST);
    assign bit_maj_s  = maj3(samp_r);
    // The stop bit is judged on the tick that takes its third sample.
    assign stop_maj_s = maj3({rx_s, samp_r[1:0]});

    // Synchroniser, frame sequencer and registered outputs; frame state moves only on DIVPULSE
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            rx_meta_r  <= 1'b1;
            rx_s       <= 1'b1;
            state_r    <= ST_IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            samp_r     <= 3'b000;
            shift_r    <= '0;
            par_r      <= 1'b0;
            data_r     <= '0;
            dvalid_r   <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            rx_meta_r <= rx.RXD;
            rx_s      <= rx_meta_r;
            dvalid_r  <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= (state_r != ST_IDLE);
            if (rx.DIVPULSE) begin
                if (in_frame_s) begin
                    if (tick_cnt_r == TICK_S0) samp_r[0] <= rx_s;
                    if (tick_cnt_r == TICK_S1) samp_r[1] <= rx_s;
                    if (tick_cnt_r == TICK_S2) samp_r[2] <= rx_s;
                    tick_cnt_r <= bit_end_s ? '0 : tick_cnt_r + TW'(1);
                end
                case (state_r)
                    ST_IDLE: begin
                        // The detecting tick is tick 0 of the start bit.
                        if (!rx_s) begin
                            state_r    <= ST_START;
                            tick_cnt_r <= TW'(1);
                        end
                    end
                    ST_START: begin
                        if (bit_end_s) begin
                            state_r   <= bit_maj_s ? ST_IDLE : ST_DATA;
                            bit_cnt_r <= 4'd0;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_s) begin
                            shift_r   <= {bit_maj_s, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == BIT_LAST) begin
                                state_r <= PAR_EN ? ST_PAR : ST_STOP;
                            end
                        end
                    end
                    ST_PAR: begin
                        if (bit_end_s) begin
                            par_r   <= bit_maj_s;
                            state_r <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (tick_cnt_r == TICK_S2) begin
                            tick_cnt_r <= '0;
                            if (stop_maj_s) begin
                                data_r   <= shift_r;
                                dvalid_r <= 1'b1;
                                perr_r   <= parity_bad(shift_r, par_r);
                                state_r  <= ST_IDLE;
                            end else begin
                                ferr_r  <= 1'b1;
                                state_r <= ST_BREAK;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        tick_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    assign rx.DATA   = data_r;
    assign rx.DVALID = dvalid_r;
    assign rx.PERR   = perr_r;
    assign rx.FERR   = ferr_r;
    assign rx.BUSY   = busy_r;
endmodule
